// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared definitions for the data-memory port arbiter: FSM state encoding,
// requester ids and a small helper for round-robin turn passing.
// Optional build macro MEM_ARB_CPU_PRIORITY_EN (used only in mem_arb_pick)
// switches the tie-break from round-robin to fixed CPU priority.
package mem_port_arbiter_pkg;

  // Arbiter FSM states. The encoding is visible on the debug state output.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RESP  = 2'b10
  } arb_state_e;

  // Requester ids, also the value driven on the grant output.
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_AUX = 1'b1;

  // With two requesters, "the one that is not the last owner" is the inverse id.
  function automatic logic other_id(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
// Combinational winner selection between the CPU (req0) and the aux master
// (req1). pick_valid says somebody is asking; pick_id names the winner.
// Build macro MEM_ARB_CPU_PRIORITY_EN: when defined the CPU wins every tie and
// last_owner is ignored; when undefined a tie goes to the requester that did
// not own the previous transaction (round-robin).
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic pick_valid,
  output logic pick_id
);

  assign pick_valid = req0 | req1;

`ifdef MEM_ARB_CPU_PRIORITY_EN
  // last_owner has no meaning under fixed priority
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  // Fixed priority: the aux master only wins when the CPU is not asking
  always_comb begin
    pick_id = REQ_CPU;
    if (!req0 && req1) pick_id = REQ_AUX;
  end
`else
  // Round-robin: a single requester wins outright, a tie passes the turn
  always_comb begin
    pick_id = REQ_CPU;
    if (req0 && req1) begin
      pick_id = other_id(last_owner);
    end else if (req1) begin
      pick_id = REQ_AUX;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one synchronous block-RAM port (one-cycle read latency) between the
// CPU control FSM (requester 0) and an auxiliary master (requester 1).
// Build macro MEM_ARB_CPU_PRIORITY_EN selects fixed CPU priority instead of
// round-robin (applied inside mem_arb_pick only).
//
// Handshake: a requester raises reqN with weN/addrN/wdataN stable and holds
// it until it sees ackN high for one cycle; rdata is valid in that same ack
// cycle. The arbiter samples requests only in IDLE, drives the memory port in
// ISSUE and acks in RESP, so a transaction takes three cycles and an acked
// requester gets one IDLE cycle to drop req or present a new request.
// A request withdrawn mid-transaction still completes and is still acked.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  arb_state_e        state_q,      state_d;
  logic              owner_q,      owner_d;
  logic              last_owner_q, last_owner_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic [DATA_W-1:0] wdata_q,      wdata_d;
  logic              we_q,         we_d;
  logic              mem_we_q,     mem_we_d;
  logic              ack0_q,       ack0_d;
  logic              ack1_q,       ack1_d;
  logic [DATA_W-1:0] rdata_q,      rdata_d;

  logic pick_valid;
  logic pick_id;

  mem_arb_pick u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_owner (last_owner_q),
    .pick_valid (pick_valid),
    .pick_id    (pick_id)
  );

  // Next-state and register-update logic for the IDLE -> ISSUE -> RESP cycle
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    mem_we_d     = 1'b0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata_d      = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_ISSUE;
          owner_d = pick_id;
          if (pick_id == REQ_CPU) begin
            addr_d   = addr0;
            wdata_d  = wdata0;
            we_d     = we0;
            mem_we_d = we0;
          end else begin
            addr_d   = addr1;
            wdata_d  = wdata1;
            we_d     = we1;
            mem_we_d = we1;
          end
        end
      end

      ST_ISSUE: begin
        // Memory captures address/write this edge; ack is shown during RESP
        state_d = ST_RESP;
        ack0_d  = (owner_q == REQ_CPU);
        ack1_d  = (owner_q == REQ_AUX);
      end

      ST_RESP: begin
        // Keep the read word so rdata stays stable after the ack cycle
        state_d      = ST_IDLE;
        last_owner_d = owner_q;
        if (!we_q) rdata_d = mem_rdata;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset also kills an in-flight write at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= REQ_CPU;
      last_owner_q <= REQ_AUX;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      mem_we_q     <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      mem_we_q     <= mem_we_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata_q      <= rdata_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = mem_we_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign grant     = owner_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

  // In the ack cycle of a read the memory word is forwarded straight through;
  // otherwise the last captured read word is held.
  assign rdata = (state_q == ST_RESP && !we_q) ? mem_rdata : rdata_q;

  // The write strobe only ever appears while the port is being driven
  a_we_in_issue : assert property (@(posedge clk) disable iff (!reset)
    mem_we |-> (state_q == ST_ISSUE));

  // Only one requester is ever acknowledged at a time
  a_ack_onehot : assert property (@(posedge clk) disable iff (!reset)
    !(ack0 && ack1));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Bench for mem_port_arbiter: a block-RAM model on the memory port, a
// reference memory that predicts read data, per-requester expected queues
// filled when a request is issued and drained by a monitor on every ack.
module tb_mem_port_arbiter;

  localparam int BOUND = 60;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [15:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, ack1, mem_we, grant, busy;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;

  // reference memory and expected queues: {is_write, expected rdata}
  logic [15:0] ref_mem [0:1023];
  logic [16:0] exp0_q[$];
  logic [16:0] exp1_q[$];
  logic [15:0] model_rdata;
  int          exp_order[4];
  int          ack_id_log[$];
  int          ack_cyc_log[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int we_cnt = 0;
  int exp_wr = 0;
  logic we_prev;

  // block-RAM model with preload/clear side port
  logic [15:0] ram [0:1023];
  logic        tb_clear, pl_en;
  logic [9:0]  pl_addr;
  logic [15:0] pl_data;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .grant(grant), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (tb_clear) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 16'h0;
    end else if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end else begin
      if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
      mem_rdata <= ram[mem_addr[9:0]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor: pops expectations on every ack, checks write strobe
  always @(negedge clk or negedge reset) begin
    logic [16:0] e;
    if (!reset) begin
      model_rdata = 16'h0;
      we_prev     = 1'b0;
    end else if (!clk) begin
      if (mem_we) begin
        check("we_in_issue", 32'(dbg_state), 32'd1);
        check("we_single_cycle", 32'(we_prev), 32'd0);
        we_cnt++;
      end
      we_prev = mem_we;
      if (ack0 || ack1) check("ack_exclusive", 32'(ack0 & ack1), 32'd0);
      for (int id = 0; id < 2; id++) begin
        if ((id == 0 && ack0) || (id == 1 && ack1)) begin
          check("ack_grant", 32'(grant), 32'(id));
          ack_id_log.push_back(id);
          ack_cyc_log.push_back(cyc);
          if ((id == 0 && exp0_q.size() == 0) || (id == 1 && exp1_q.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL unexpected_ack: id=%0d got ack=1 want 0", id);
          end else begin
            e = (id == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
            if (!e[16]) begin
              check("rdata", 32'(rdata), 32'(e[15:0]));
              model_rdata = e[15:0];
            end else begin
              check("rdata_hold", 32'(rdata), 32'(model_rdata));
            end
          end
        end
      end
    end
  end

  // driver: one transaction for requester id; hold keeps req high afterwards
  task automatic txn(input int id, input logic we, input logic [15:0] addr,
                     input logic [15:0] wdata, input bit hold, input bit chk);
    logic [16:0] e;
    int lat;
    bit got;
    @(posedge clk); #1;
    if (we) begin
      ref_mem[addr[9:0]] = wdata;
      exp_wr++;
      e = {1'b1, 16'h0};
    end else begin
      e = {1'b0, ref_mem[addr[9:0]]};
    end
    if (id == 0) begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; exp0_q.push_back(e);
    end else begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; exp1_q.push_back(e);
    end
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= BOUND; i++) begin
      @(negedge clk);
      if (chk && i == 2) begin
        check("issue_addr", 32'(mem_addr), 32'(addr));
        check("issue_we", 32'(mem_we), 32'(we));
        if (we) check("issue_wdata", 32'(mem_wdata), 32'(wdata));
      end
      if ((id == 0 && ack0) || (id == 1 && ack1)) begin
        got = 1'b1;
        lat = i;
        break;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL ack_timeout: id=%0d got no ack want ack within %0d cycles", id, BOUND);
    end
    if (chk) check("ack_latency", 32'(lat), 32'd3);
    if (!hold || !got) begin
      @(posedge clk); #1;
      if (id == 0) req0 = 1'b0; else req1 = 1'b0;
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test want finish");
    $fatal(1);
  end

  initial begin
    int w0;
    reset = 1'b0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    tb_clear = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 16'h0;
`ifdef MEM_ARB_CPU_PRIORITY_EN
    exp_order = '{0, 0, 1, 1};
`else
    exp_order = '{0, 1, 0, 1};
`endif

    // reset state
    repeat (2) @(negedge clk);
    check("rst_ack0", 32'(ack0), 0);
    check("rst_ack1", 32'(ack1), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_state", 32'(dbg_state), 0);
    tb_clear = 1'b0;
    preload(10'h010, 16'hBEEF);
    preload(10'h030, 16'hAAAA);
    @(negedge clk);
    reset = 1'b1;

    // single CPU read, then aux write and CPU read-back
    txn(0, 1'b0, 16'h0010, 16'h0, 0, 1);
    w0 = we_cnt;
    txn(1, 1'b1, 16'h0020, 16'h1234, 0, 1);
    check("aux_write_pulses", 32'(we_cnt - w0), 1);
    txn(0, 1'b0, 16'h0020, 16'h0, 0, 1);

    // simultaneous requests from reset, each held for two transactions
    do_reset();
    ack_id_log.delete();
    ack_cyc_log.delete();
    fork
      begin
        txn(0, 1'b0, 16'h0010, 16'h0, 1, 0);
        txn(0, 1'b0, 16'h0020, 16'h0, 0, 0);
      end
      begin
        txn(1, 1'b0, 16'h0020, 16'h0, 1, 0);
        txn(1, 1'b0, 16'h0010, 16'h0, 0, 0);
      end
    join
    check("order_len", 32'(ack_id_log.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < ack_id_log.size()) check("ack_order", 32'(ack_id_log[i]), 32'(exp_order[i]));
      if (i > 0 && i < ack_cyc_log.size())
        check("ack_spacing", 32'(ack_cyc_log[i] - ack_cyc_log[i-1]), 3);
    end

    // reset pulse during ISSUE of a write
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0030; wdata0 = 16'h5555;
    @(posedge clk); #1;
    check("abort_we_before", 32'(mem_we), 1);
    #1 reset = 1'b0;
    #1;
    check("abort_we_async", 32'(mem_we), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_state", 32'(dbg_state), 0);
    check("abort_ack0", 32'(ack0), 0);
    req0 = 1'b0; we0 = 1'b0;
    #1 reset = 1'b1;
    txn(0, 1'b0, 16'h0030, 16'h0, 0, 1);

    // req0 withdrawn during ISSUE still gets its ack
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
    exp0_q.push_back({1'b0, ref_mem[10'h010]});
    @(posedge clk); #1;
    req0 = 1'b0;
    check("drop_state_issue", 32'(dbg_state), 1);
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < BOUND; i++) begin
        @(negedge clk);
        if (ack0) begin got = 1'b1; break; end
      end
      check("drop_ack_seen", 32'(got), 1);
      @(posedge clk); #1;
      check("drop_back_idle", 32'(dbg_state), 0);
    end

    // randomized concurrent traffic on disjoint address windows
    fork
      begin
        for (int k = 0; k < 25; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          txn(0, 1'($urandom_range(0, 1)), 16'h0100 + 16'($urandom_range(0, 15)),
              16'($urandom), 0, 0);
        end
      end
      begin
        for (int k = 0; k < 25; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          txn(1, 1'($urandom_range(0, 1)), 16'h0200 + 16'($urandom_range(0, 15)),
              16'($urandom), 0, 0);
        end
      end
    join

    // idle with no requests
    repeat (20) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 0);
      check("idle_mem_we", 32'(mem_we), 0);
      check("idle_acks", 32'(ack0 | ack1), 0);
    end

    check("write_pulse_count", 32'(we_cnt), 32'(exp_wr));
    check("exp0_drained", 32'(exp0_q.size()), 0);
    check("exp1_drained", 32'(exp1_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
